// File: rtl/timer_if.sv
// CPU system-bus signals seen by a memory-mapped responder.
// The CPU side drives the master modport; peripherals take the slave modport.
interface timer_if;
  logic [1:0]  t_cycle;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_write;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic        mem_selected;

  modport master (
    output t_cycle, mem_addr, mem_enable, mem_write, mem_data_in,
    input  mem_data_out, mem_selected
  );

  modport slave (
    input  t_cycle, mem_addr, mem_enable, mem_write, mem_data_in,
    output mem_data_out, mem_selected
  );
endinterface

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer: free-running 16-bit system counter, falling-edge tick
// detector on a selectable counter tap, and TIMA overflow/reload sequencing with IRQ.
module timer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus,
  output logic   irq_timer
);
  typedef enum logic [1:0] {RUN = 2'd0, OVF = 2'd1, RELOAD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [15:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [1:0]  sub_q, sub_d;
  logic        edge_prev_q, edge_prev_d;
  logic        irq_q, irq_d;

  logic [15:0] offs;
  logic        selected, wr;
  logic        wr_div, wr_tima, wr_tma, wr_tac;
  logic        tap, edge_in, tick;

  // Unsigned wrap makes any address below BASE_ADDR land far outside 0..3.
  assign offs     = bus.mem_addr - BASE_ADDR;
  assign selected = bus.mem_enable && (offs[15:2] == 14'd0);
  assign wr       = selected && bus.mem_write && (bus.t_cycle == 2'd3);
  assign wr_div   = wr && (offs[1:0] == 2'd0);
  assign wr_tima  = wr && (offs[1:0] == 2'd1);
  assign wr_tma   = wr && (offs[1:0] == 2'd2);
  assign wr_tac   = wr && (offs[1:0] == 2'd3);

  assign bus.mem_selected = selected;
  assign irq_timer        = irq_q;

  always_comb begin
    bus.mem_data_out = 8'hFF;
    if (selected) begin
      case (offs[1:0])
        2'd0:    bus.mem_data_out = sys_cnt_q[15:8];
        2'd1:    bus.mem_data_out = tima_q;
        2'd2:    bus.mem_data_out = tma_q;
        default: bus.mem_data_out = {5'b11111, tac_q};
      endcase
    end
  end

  // Tick sees the post-write counter and TAC, so DIV resets and TAC changes can glitch a tick.
  always_comb begin
    sys_cnt_d = wr_div ? 16'd0 : sys_cnt_q + 16'd1;
    tac_d     = wr_tac ? bus.mem_data_in[2:0] : tac_q;
    tma_d     = wr_tma ? bus.mem_data_in : tma_q;
    case (tac_d[1:0])
      2'b00:   tap = sys_cnt_d[9];
      2'b01:   tap = sys_cnt_d[3];
      2'b10:   tap = sys_cnt_d[5];
      default: tap = sys_cnt_d[7];
    endcase
    edge_in     = tac_d[2] & tap;
    edge_prev_d = edge_in;
    tick        = edge_prev_q & ~edge_in;
  end

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    tima_d  = tima_q;
    irq_d   = 1'b0;
    case (state_q)
      RUN: begin
        if (wr_tima) begin
          tima_d = bus.mem_data_in;
        end else if (tick) begin
          if (tima_q == 8'hFF) begin
            tima_d  = 8'h00;
            state_d = OVF;
            sub_d   = 2'd0;
          end else begin
            tima_d = tima_q + 8'd1;
          end
        end
      end
      OVF: begin
        if (wr_tima) begin
          tima_d  = bus.mem_data_in;
          state_d = RUN;
        end else if (sub_q == 2'd3) begin
          tima_d  = tma_d;
          irq_d   = 1'b1;
          state_d = RELOAD;
          sub_d   = 2'd0;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      RELOAD: begin
        if (wr_tma) tima_d = bus.mem_data_in;
        if (sub_q == 2'd3) begin
          state_d = RUN;
          sub_d   = 2'd0;
        end else begin
          sub_d = sub_q + 2'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      sub_q       <= 2'd0;
      sys_cnt_q   <= 16'd0;
      tima_q      <= 8'd0;
      tma_q       <= 8'd0;
      tac_q       <= 3'd0;
      edge_prev_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      sys_cnt_q   <= sys_cnt_d;
      tima_q      <= tima_d;
      tma_q       <= tma_d;
      tac_q       <= tac_d;
      edge_prev_q <= edge_prev_d;
      irq_q       <= irq_d;
    end
  end
endmodule
